// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID valid/ready register slice with one skid entry, flush, and MIPS field decode.
// Define IFID_PERF_CNT_EN to add the perfFetched/perfStallCyc/perfFlushed counters.
module if_id_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ifInstr,
    input  logic [WIDTH-1:0] ifPcPlus4,
    input  logic             ifValid,
    output logic             ifReady,
    input  logic             flush,
    input  logic             idStall,
    output logic             idValid,
    output logic [WIDTH-1:0] idInstr,
    output logic [WIDTH-1:0] idPcPlus4,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [31:0]      immSext,
    output logic [31:0]      jumpTarget
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]      perfFetched,
    output logic [31:0]      perfStallCyc,
    output logic [31:0]      perfFlushed
`endif
);
    logic             oValid, sValid;
    logic [WIDTH-1:0] oInstr, oPc4, sInstr, sPc4;
    logic             accept;

    // ifReady depends only on the skid flop, so idStall never reaches IF combinationally
    assign ifReady = !sValid;
    assign accept  = ifValid && ifReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid <= 1'b0;
            oInstr <= NOP_INSTR;
            oPc4   <= '0;
            sValid <= 1'b0;
            sInstr <= '0;
            sPc4   <= '0;
        end else if (flush) begin
            oValid <= 1'b0;
            oInstr <= NOP_INSTR;
            oPc4   <= '0;
            sValid <= 1'b0;
        end else if (idStall) begin
            if (accept) begin
                sValid <= 1'b1;
                sInstr <= ifInstr;
                sPc4   <= ifPcPlus4;
            end
        end else if (sValid) begin
            oValid <= 1'b1;
            oInstr <= sInstr;
            oPc4   <= sPc4;
            sValid <= accept;
            if (accept) begin
                sInstr <= ifInstr;
                sPc4   <= ifPcPlus4;
            end
        end else if (accept) begin
            oValid <= 1'b1;
            oInstr <= ifInstr;
            oPc4   <= ifPcPlus4;
        end else begin
            oValid <= 1'b0;
            oInstr <= NOP_INSTR;
        end
    end

    // oInstr is forced to NOP_INSTR on every path that clears oValid
    assign idValid    = oValid;
    assign idInstr    = oInstr;
    assign idPcPlus4  = oPc4;
    assign opcode     = idInstr[31:26];
    assign rs         = idInstr[25:21];
    assign rt         = idInstr[20:16];
    assign rd         = idInstr[15:11];
    assign shamt      = idInstr[10:6];
    assign funct      = idInstr[5:0];
    assign immSext    = {{16{idInstr[15]}}, idInstr[15:0]};
    assign jumpTarget = {idPcPlus4[31:28], idInstr[25:0], 2'b00};

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfFetched  <= '0;
            perfStallCyc <= '0;
            perfFlushed  <= '0;
        end else begin
            perfFetched  <= perfFetched + 32'(accept);
            perfStallCyc <= perfStallCyc + 32'(idStall && oValid);
            if (flush)
                perfFlushed <= perfFlushed + 32'(oValid) + 32'(sValid) + 32'(accept);
        end
    end
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed self-checking bench for if_id_stage.
// Counter checks are compiled in when IFID_PERF_CNT_EN is defined.
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ifInstr, ifPcPlus4;
    logic        ifValid, ifReady, flush, idStall, idValid;
    logic [31:0] idInstr, idPcPlus4, immSext, jumpTarget;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] perfFetched, perfStallCyc, perfFlushed;
`endif
    int nCmp = 0;
    int nErr = 0;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .ifInstr(ifInstr), .ifPcPlus4(ifPcPlus4),
        .ifValid(ifValid), .ifReady(ifReady), .flush(flush), .idStall(idStall),
        .idValid(idValid), .idInstr(idInstr), .idPcPlus4(idPcPlus4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immSext(immSext), .jumpTarget(jumpTarget)
`ifdef IFID_PERF_CNT_EN
        , .perfFetched(perfFetched), .perfStallCyc(perfStallCyc), .perfFlushed(perfFlushed)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        ifValid = v;
        ifInstr = ins;
        ifPcPlus4 = pc;
    endtask

    task automatic test_reset;
        drive(1, 32'h1111_1111, 32'h100);
        step;
        idStall = 1;
        drive(1, 32'h2222_2222, 32'h104);
        step;
        nCmp++; if (ifReady !== 1'b0) begin nErr++; $display("FAIL rst_pre_ready: got %b want 0", ifReady); end
        nCmp++; if (idInstr !== 32'h1111_1111) begin nErr++; $display("FAIL rst_pre_instr: got %h want 11111111", idInstr); end
        rst_n = 0;
        #1;
        nCmp++; if (idValid !== 1'b0) begin nErr++; $display("FAIL rst_valid: got %b want 0", idValid); end
        nCmp++; if (idInstr !== 32'h0) begin nErr++; $display("FAIL rst_instr: got %h want 0", idInstr); end
        nCmp++; if (ifReady !== 1'b1) begin nErr++; $display("FAIL rst_ready: got %b want 1", ifReady); end
        nCmp++; if (idPcPlus4 !== 32'h0) begin nErr++; $display("FAIL rst_pc4: got %h want 0", idPcPlus4); end
        idStall = 0;
        drive(0, 0, 0);
        step;
        rst_n = 1;
        drive(1, 32'h8C22_0004, 32'h4);
        step;
        drive(0, 0, 0);
        nCmp++; if (idValid !== 1'b1) begin nErr++; $display("FAIL first_valid: got %b want 1", idValid); end
        nCmp++; if (idInstr !== 32'h8C22_0004) begin nErr++; $display("FAIL first_instr: got %h want 8c220004", idInstr); end
        nCmp++; if (idPcPlus4 !== 32'h4) begin nErr++; $display("FAIL first_pc4: got %h want 4", idPcPlus4); end
        nCmp++; if (opcode !== 6'h23) begin nErr++; $display("FAIL first_opcode: got %h want 23", opcode); end
        nCmp++; if (rs !== 5'd1) begin nErr++; $display("FAIL first_rs: got %0d want 1", rs); end
        nCmp++; if (rt !== 5'd2) begin nErr++; $display("FAIL first_rt: got %0d want 2", rt); end
        nCmp++; if (immSext !== 32'h4) begin nErr++; $display("FAIL first_imm: got %h want 4", immSext); end
        step;
        nCmp++; if (idValid !== 1'b0 || idInstr !== 32'h0) begin nErr++; $display("FAIL first_drain: got v=%b i=%h want v=0 i=0", idValid, idInstr); end
    endtask

    task automatic test_stream;
        logic [31:0] ins [4] = '{32'h0043_0820, 32'h2003_FFFF, 32'h0800_0010, 32'h1022_0003};
        logic [31:0] pcs [4] = '{32'h10, 32'h14, 32'h4000_0008, 32'h1C};
        for (int i = 0; i < 4; i++) begin
            drive(1, ins[i], pcs[i]);
            step;
            nCmp++; if (idValid !== 1'b1 || idInstr !== ins[i] || idPcPlus4 !== pcs[i])
                begin nErr++; $display("FAIL stream%0d: got v=%b i=%h p=%h want v=1 i=%h p=%h", i, idValid, idInstr, idPcPlus4, ins[i], pcs[i]); end
            if (i == 0) begin
                nCmp++; if (rd !== 5'd1 || funct !== 6'h20 || rs !== 5'd2 || rt !== 5'd3)
                    begin nErr++; $display("FAIL stream_rtype: got rs=%0d rt=%0d rd=%0d f=%h want 2 3 1 20", rs, rt, rd, funct); end
            end
            if (i == 1) begin
                nCmp++; if (immSext !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL stream_imm: got %h want ffffffff", immSext); end
            end
            if (i == 2) begin
                nCmp++; if (jumpTarget !== 32'h4000_0040) begin nErr++; $display("FAIL stream_jt: got %h want 40000040", jumpTarget); end
            end
            nCmp++; if (ifReady !== 1'b1) begin nErr++; $display("FAIL stream_ready%0d: got %b want 1", i, ifReady); end
        end
        drive(0, 0, 0);
        step;
        nCmp++; if (idValid !== 1'b0) begin nErr++; $display("FAIL stream_end: got %b want 0", idValid); end
    endtask

    task automatic test_stall;
        drive(1, 32'hA000_0001, 32'h200);
        step;
        idStall = 1;
        drive(1, 32'hB000_0002, 32'h204);
        step;
        drive(1, 32'hC000_0003, 32'h208);
        for (int i = 0; i < 2; i++) begin
            nCmp++; if (ifReady !== 1'b0) begin nErr++; $display("FAIL stall_ready%0d: got %b want 0", i, ifReady); end
            nCmp++; if (idInstr !== 32'hA000_0001 || idValid !== 1'b1) begin nErr++; $display("FAIL stall_hold%0d: got v=%b i=%h want v=1 i=a0000001", i, idValid, idInstr); end
            step;
        end
        nCmp++; if (idInstr !== 32'hA000_0001) begin nErr++; $display("FAIL stall_hold2: got %h want a0000001", idInstr); end
        idStall = 0;
        step;
        nCmp++; if (idInstr !== 32'hB000_0002 || idPcPlus4 !== 32'h204) begin nErr++; $display("FAIL stall_drain: got i=%h p=%h want b0000002 204", idInstr, idPcPlus4); end
        nCmp++; if (ifReady !== 1'b1) begin nErr++; $display("FAIL stall_ready_back: got %b want 1", ifReady); end
        step;
        drive(0, 0, 0);
        nCmp++; if (idInstr !== 32'hC000_0003 || idPcPlus4 !== 32'h208) begin nErr++; $display("FAIL stall_next: got i=%h p=%h want c0000003 208", idInstr, idPcPlus4); end
        step;
        nCmp++; if (idValid !== 1'b0) begin nErr++; $display("FAIL stall_end: got %b want 0", idValid); end
    endtask

    task automatic test_flush;
`ifdef IFID_PERF_CNT_EN
        logic [31:0] f0;
`endif
        drive(1, 32'hD000_0001, 32'h300);
        step;
        idStall = 1;
        drive(1, 32'hD000_0002, 32'h304);
        step;
        drive(1, 32'hD000_0003, 32'h308);
`ifdef IFID_PERF_CNT_EN
        f0 = perfFlushed;
`endif
        flush = 1;
        step;
        flush = 0;
        idStall = 0;
        drive(0, 0, 0);
        nCmp++; if (idValid !== 1'b0) begin nErr++; $display("FAIL flush_valid: got %b want 0", idValid); end
        nCmp++; if (idInstr !== 32'h0) begin nErr++; $display("FAIL flush_instr: got %h want 0", idInstr); end
        nCmp++; if (idPcPlus4 !== 32'h0) begin nErr++; $display("FAIL flush_pc4: got %h want 0", idPcPlus4); end
        nCmp++; if (ifReady !== 1'b1) begin nErr++; $display("FAIL flush_ready: got %b want 1", ifReady); end
`ifdef IFID_PERF_CNT_EN
        // skid full blocks the incoming beat, so O and S are the two killed beats
        nCmp++; if (perfFlushed - f0 !== 32'd2) begin nErr++; $display("FAIL flush_perf: got %0d want 2", perfFlushed - f0); end
`endif
        step;
        nCmp++; if (idValid !== 1'b0) begin nErr++; $display("FAIL flush_after: got %b want 0", idValid); end
    endtask

    task automatic test_flush_stall;
        drive(1, 32'hE000_0001, 32'h400);
        step;
        flush = 1;
        idStall = 1;
        drive(1, 32'hE000_0002, 32'h404);
        step;
        flush = 0;
        idStall = 0;
        nCmp++; if (idValid !== 1'b0 || ifReady !== 1'b1) begin nErr++; $display("FAIL fs_drop: got v=%b r=%b want v=0 r=1", idValid, ifReady); end
        drive(1, 32'hE000_0003, 32'h408);
        step;
        drive(0, 0, 0);
        nCmp++; if (idValid !== 1'b1 || idInstr !== 32'hE000_0003 || idPcPlus4 !== 32'h408) begin nErr++; $display("FAIL fs_next: got v=%b i=%h p=%h want 1 e0000003 408", idValid, idInstr, idPcPlus4); end
        step;
        nCmp++; if (idValid !== 1'b0) begin nErr++; $display("FAIL fs_end: got %b want 0", idValid); end
    endtask

    initial begin
        rst_n = 0;
        flush = 0;
        idStall = 0;
        drive(0, 0, 0);
        step;
        step;
        rst_n = 1;
        test_reset;
        test_stream;
        test_stall;
        test_flush;
        test_flush_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
